// File: rtl/dual_slope_integrator_if.sv
// rtl/dual_slope_integrator_if.sv - switch commands in, integrator observation out
interface dual_slope_integrator_if #(
  parameter int WIDTH    = 20,
  parameter int VM_WIDTH = 10
);
  logic                ch_vm;
  logic                ch_vr;
  logic                ch_zr;
  logic [VM_WIDTH-1:0] vm;
  logic                Vint_z;
  logic [WIDTH-1:0]    vint;
  logic [2:0]          phase;
  logic                ovf;
  logic                err;
  logic [15:0]         up_cycles;

  modport master (
    output ch_vm, ch_vr, ch_zr, vm,
    input  Vint_z, vint, phase, ovf, err, up_cycles
  );

  modport slave (
    input  ch_vm, ch_vr, ch_zr, vm,
    output Vint_z, vint, phase, ovf, err, up_cycles
  );
endinterface

// File: rtl/dual_slope_integrator.sv
// rtl/dual_slope_integrator.sv - cycle model of the dual-slope analog front end
module dual_slope_integrator #(
  parameter int WIDTH    = 20,
  parameter int VM_WIDTH = 10,
  parameter int VREF     = 1000
) (
  input logic                    clk,
  input logic                    rst_s,
  dual_slope_integrator_if.slave fe
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INTEG = 3'd1;
  localparam logic [2:0] S_DEINT = 3'd2;
  localparam logic [2:0] S_ZERO  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [WIDTH-1:0] ACC_MAX = '1;
  localparam logic [WIDTH-1:0] VREF_W  = WIDTH'(VREF);

  logic [2:0]          state_q, state_d;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic [VM_WIDTH-1:0] vm_hold_q, vm_hold_d;
  logic [15:0]         up_q, up_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;

  logic                entry;
  logic [VM_WIDTH-1:0] sample;
  logic [WIDTH:0]      sum;

  always_comb begin
    state_d = S_ERR;
    if (state_q != S_ERR) begin
      unique case ({fe.ch_vm, fe.ch_vr, fe.ch_zr})
        3'b000:  state_d = S_IDLE;
        3'b100:  state_d = S_INTEG;
        3'b010:  state_d = S_DEINT;
        3'b001:  state_d = S_ZERO;
        default: state_d = S_ERR;
      endcase
    end
  end

  // The entry edge integrates the live vm; later edges use the captured copy.
  assign entry  = (state_q != S_INTEG);
  assign sample = entry ? fe.vm : vm_hold_q;
  assign sum    = {1'b0, acc_q} + (WIDTH+1)'(sample);

  always_comb begin
    acc_d     = acc_q;
    vm_hold_d = vm_hold_q;
    up_d      = up_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    unique case (state_d)
      S_INTEG: begin
        if (entry) begin
          vm_hold_d = fe.vm;
          up_d      = 16'd1;
        end else if (up_q != 16'hFFFF) begin
          up_d = up_q + 16'd1;
        end
        if (sum[WIDTH]) begin
          acc_d = ACC_MAX;
          ovf_d = 1'b1;
        end else begin
          acc_d = sum[WIDTH-1:0];
        end
      end
      S_DEINT: acc_d = (acc_q < VREF_W) ? '0 : acc_q - VREF_W;
      S_ZERO: begin
        acc_d = '0;
        ovf_d = 1'b0;
      end
      S_ERR:   err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      vm_hold_q <= '0;
      up_q      <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      vm_hold_q <= vm_hold_d;
      up_q      <= up_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
    end
  end

  assign fe.Vint_z    = (state_q == S_DEINT) && (acc_q == '0);
  assign fe.vint      = acc_q;
  assign fe.phase     = {state_q == S_INTEG, state_q == S_DEINT, state_q == S_ZERO};
  assign fe.ovf       = ovf_q;
  assign fe.err       = err_q;
  assign fe.up_cycles = up_q;

endmodule

// File: tb/tb_dual_slope_integrator.sv
// tb/tb_dual_slope_integrator.sv - random and directed check against a behavioural model
`timescale 1ns/1ps
module tb_dual_slope_integrator;
  localparam int AW = 20, AV = 10, AREF = 1000;
  localparam int BW = 10, BV = 10, BREF = 10;
  localparam int MI = 0, MG = 1, MD = 2, MZ = 3, ME = 4;

  typedef struct {
    int     mode;
    longint acc;
    longint hold;
    longint up;
    bit     ovf;
    bit     err;
  } mdl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  mdl_t ma, mb;

  always #5 clk = ~clk;

  dual_slope_integrator_if #(.WIDTH(AW), .VM_WIDTH(AV)) a_if ();
  dual_slope_integrator_if #(.WIDTH(BW), .VM_WIDTH(BV)) b_if ();

  dual_slope_integrator #(.WIDTH(AW), .VM_WIDTH(AV), .VREF(AREF)) dut_a (
    .clk(clk), .rst_s(rst), .fe(a_if.slave));
  dual_slope_integrator #(.WIDTH(BW), .VM_WIDTH(BV), .VREF(BREF)) dut_b (
    .clk(clk), .rst_s(rst), .fe(b_if.slave));

  function automatic mdl_t mreset();
    mdl_t m;
    m.mode = MI; m.acc = 0; m.hold = 0; m.up = 0; m.ovf = 0; m.err = 0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t m, logic [2:0] sw, longint vm, int w, longint vref);
    mdl_t n;
    longint top;
    int nm;
    n = m;
    top = (longint'(1) << w) - 1;
    if (m.mode == ME) nm = ME;
    else if (sw == 3'b000) nm = MI;
    else if (sw == 3'b100) nm = MG;
    else if (sw == 3'b010) nm = MD;
    else if (sw == 3'b001) nm = MZ;
    else nm = ME;
    if (nm == MG) begin
      if (m.mode != MG) begin
        n.hold = vm;
        n.up = 1;
      end else begin
        n.up = (m.up >= 65535) ? 65535 : m.up + 1;
      end
      n.acc = m.acc + n.hold;
      if (n.acc > top) begin
        n.acc = top;
        n.ovf = 1;
      end
    end else if (nm == MD) begin
      n.acc = (m.acc < vref) ? 0 : m.acc - vref;
    end else if (nm == MZ) begin
      n.acc = 0;
      n.ovf = 0;
    end else if (nm == ME) begin
      n.err = 1;
    end
    n.mode = nm;
    return n;
  endfunction

  function automatic longint mphase(mdl_t m);
    return (m.mode == MG) ? 4 : (m.mode == MD) ? 2 : (m.mode == MZ) ? 1 : 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= mreset();
      mb <= mreset();
    end else begin
      ma <= mstep(ma, {a_if.ch_vm, a_if.ch_vr, a_if.ch_zr}, longint'(a_if.vm), AW, AREF);
      mb <= mstep(mb, {b_if.ch_vm, b_if.ch_vr, b_if.ch_zr}, longint'(b_if.vm), BW, BREF);
    end
  end

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_vint", longint'(a_if.vint), ma.acc);
      check("a_vintz", longint'(a_if.Vint_z), longint'(ma.mode == MD && ma.acc == 0));
      check("a_phase", longint'(a_if.phase), mphase(ma));
      check("a_ovf", longint'(a_if.ovf), longint'(ma.ovf));
      check("a_err", longint'(a_if.err), longint'(ma.err));
      check("a_up", longint'(a_if.up_cycles), ma.up);
      check("b_vint", longint'(b_if.vint), mb.acc);
      check("b_vintz", longint'(b_if.Vint_z), longint'(mb.mode == MD && mb.acc == 0));
      check("b_phase", longint'(b_if.phase), mphase(mb));
      check("b_ovf", longint'(b_if.ovf), longint'(mb.ovf));
      check("b_err", longint'(b_if.err), longint'(mb.err));
    end
  end

  task automatic set_a(input logic [2:0] sw, input int vm);
    {a_if.ch_vm, a_if.ch_vr, a_if.ch_zr} = sw;
    a_if.vm = AV'(vm);
  endtask

  task automatic set_b(input logic [2:0] sw, input int vm);
    {b_if.ch_vm, b_if.ch_vr, b_if.ch_zr} = sw;
    b_if.vm = BV'(vm);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rst();
    #2 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    int k;
    set_a(3'b000, 0);
    set_b(3'b000, 0);
    #12;
    check("rst_vint", longint'(a_if.vint), 0);
    check("rst_phase", longint'(a_if.phase), 0);
    check("rst_vintz", longint'(a_if.Vint_z), 0);
    check("rst_err", longint'(a_if.err), 0);
    check("rst_up", longint'(a_if.up_cycles), 0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    set_a(3'b100, 437);
    cyc(1000);
    check("integ_vint", longint'(a_if.vint), 437000);
    check("integ_up", longint'(a_if.up_cycles), 1000);
    set_a(3'b010, 437);
    k = 0;
    while (k < 2000 && a_if.Vint_z !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    check("deint_edges", k, 437);
    cyc(3);
    check("vintz_held", longint'(a_if.Vint_z), 1);
    set_a(3'b000, 437);
    cyc(1);
    check("vintz_drop", longint'(a_if.Vint_z), 0);
    set_a(3'b001, 0);
    cyc(1);

    set_a(3'b100, 437);
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      if (i == 5) a_if.vm = AV'(900);
    end
    check("vm_ignored", longint'(a_if.vint), 437000);
    set_a(3'b010, 0);
    cyc(435);
    check("mid_deint", longint'(a_if.vint), 2000);
    #2 rst = 1'b1;
    #1;
    check("async_vint", longint'(a_if.vint), 0);
    check("async_vintz", longint'(a_if.Vint_z), 0);
    check("async_phase", longint'(a_if.phase), 0);
    rst = 1'b0;
    cyc(1);
    check("deint_from_zero", longint'(a_if.Vint_z), 1);
    set_a(3'b000, 0);

    set_b(3'b100, 1023);
    cyc(2);
    check("sat_vint", longint'(b_if.vint), 1023);
    check("sat_ovf", longint'(b_if.ovf), 1);
    set_b(3'b001, 0);
    cyc(1);
    check("zero_vint", longint'(b_if.vint), 0);
    check("zero_ovf", longint'(b_if.ovf), 0);
    set_b(3'b100, 5);
    cyc(3);
    check("b_acc15", longint'(b_if.vint), 15);
    set_b(3'b010, 5);
    cyc(1);
    check("clamp_step1", longint'(b_if.vint), 5);
    check("clamp_vintz1", longint'(b_if.Vint_z), 0);
    cyc(1);
    check("clamp_step2", longint'(b_if.vint), 0);
    check("clamp_vintz2", longint'(b_if.Vint_z), 1);
    set_b(3'b000, 5);
    cyc(1);
    check("clamp_drop", longint'(b_if.Vint_z), 0);
    set_b(3'b110, 5);
    cyc(1);
    check("err_set", longint'(b_if.err), 1);
    check("err_phase", longint'(b_if.phase), 0);
    set_b(3'b100, 7);
    cyc(3);
    check("err_absorb", longint'(b_if.vint), 0);
    check("err_phase2", longint'(b_if.phase), 0);
    pulse_rst();
    #1;
    check("err_clear", longint'(b_if.err), 0);
    @(negedge clk);

    for (int seg = 0; seg < 150; seg++) begin
      int len;
      logic [2:0] swa, swb;
      swa = 3'(1 << $urandom_range(0, 2));
      swb = 3'(1 << $urandom_range(0, 2));
      if ($urandom_range(0, 5) == 0) swa = 3'b000;
      if ($urandom_range(0, 40) == 0) swa = 3'b111;
      if ($urandom_range(0, 30) == 0) swb = 3'b011;
      len = $urandom_range(1, 40);
      for (int c = 0; c < len; c++) begin
        set_a(swa, int'($urandom_range(0, 1023)));
        set_b(swb, int'($urandom_range(0, 1023)));
        @(negedge clk);
      end
      if (ma.err || mb.err) begin
        pulse_rst();
        @(negedge clk);
      end
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dual_slope_integrator.md
# dual_slope_integrator

Cycle-accurate digital model of the dual-slope converter's analog front end (input switches, integrator, zero comparator). It is the responder to the conversion controller. It receives the `ch_vm` / `ch_vr` / `ch_zr` switch commands and returns `Vint_z`, so the whole converter can be simulated and emulated on FPGA without the analog board. It sits beside the controller in the converter top level, with `Vint_z` wired to the controller's zero-detect input.

## Interface

Parameters:
- `WIDTH`, default 20: integrator accumulator width in bits.
- `VM_WIDTH`, default 10: width of the measured-voltage code.
- `VREF`, default 1000: amount subtracted from the accumulator per de-integrate cycle; must be ≥1 and <2^VM_WIDTH.

Ports:
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `rst_s`, input, 1: asynchronous, active-high reset.
- `ch_vm`, input, 1: integrate-Vm switch command.
- `ch_vr`, input, 1: de-integrate-Vref switch command.
- `ch_zr`, input, 1: integrator zeroing switch command.
- `vm`, input, VM_WIDTH: unsigned measured-voltage code.
- `Vint_z`, output, 1: integrator at zero during de-integration.
- `vint`, output, WIDTH: accumulator value, for observation.
- `phase`, output, 3: one-hot current phase {INTEG, DEINT, ZERO}; 000 = IDLE or ERR.
- `ovf`, output, 1: sticky accumulator saturation flag.
- `err`, output, 1: sticky illegal switch combination flag.
- `up_cycles`, output, 16: integrate edges since the last entry into INTEG.

## Operation

- States are IDLE, INTEG, DEINT, ZERO and ERR.
- Each edge, the switch vector {ch_vm, ch_vr, ch_zr} selects the next state:
  - 000 → IDLE
  - 100 → INTEG
  - 010 → DEINT
  - 001 → ZERO
  - any other value → ERR
- ERR is absorbing until `rst_s`. In ERR, `err`=1, the accumulator is held and `Vint_z`=0.
- INTEG:
  - On the first edge entering INTEG from any other state, `vm` is captured into `vm_hold` and `up_cycles` is set to 1.
  - Each edge, the accumulator adds the effective sample: `vm` on the entry edge, `vm_hold` on later edges. `up_cycles` increments, saturating at 16'hFFFF.
  - Changes on `vm` after the entry edge are ignored.
- DEINT: each edge, `acc` becomes `acc − VREF`; if `acc < VREF`, `acc` is clamped to 0. A zero accumulator stays 0.
- ZERO: `acc` is cleared to 0 on the edge and `ovf` is cleared.
- IDLE: `acc`, `vm_hold` and `up_cycles` are held.
- The accumulator is not cleared on entry to INTEG. Only ZERO or reset clears it.
- Arithmetic is unsigned. The sum is computed at WIDTH+1 bits. If it exceeds 2^WIDTH−1, `acc` saturates at all-ones and `ovf` sets.
- `Vint_z` = (state == DEINT) && (acc == 0), decoded from registers, so it has no combinational path from inputs.
- `vint` = `acc`.
- `phase` is decoded from the state register.

## Timing

- Reset values: state IDLE, `acc`=0, `vm_hold`=0, `up_cycles`=0, `Vint_z`=0, `vint`=0, `phase`=000, `ovf`=0, `err`=0.
- Latency is one edge from a switch command to the `acc`/`phase` update.
- `Vint_z` rises in the same cycle the accumulator reaches 0 in DEINT, that is, after edge number ceil(acc_start/VREF) of DEINT.
- `Vint_z` stays high while `ch_vr` is held.
- `Vint_z` drops on the edge that samples `ch_vr`=0.
- DEINT entered with `acc`=0 gives `Vint_z`=1 after the first DEINT edge.
- With N integrate edges and `VREF`=1000, the DEINT edge count to zero is ceil(N·vm/1000); for N=1000 this is exactly `vm`.
- `rst_s` asserted mid-conversion clears everything immediately, without waiting for a clock. Operation resumes on the first edge after release.
- A glitch of 110 lasting even one edge forces ERR.

## Test plan

- Reset, then `vm`=437, 1000 edges `ch_vm`, then `ch_vr` → `vint`=437000 at the end of INTEG; `Vint_z` rises after exactly 437 DEINT edges; `up_cycles`=1000.
- `vm`=437 captured on entry, then `vm` changed to 900 at INTEG edge 5, 1000 edges total → `vint`=437000 (change ignored).
- `vm`=1023 with `WIDTH`=10, 2 INTEG edges → `vint`=1023 and `ovf`=1; one ZERO edge → `vint`=0 and `ovf`=0.
- `vm`=5, 3 INTEG edges (`acc`=15), `VREF`=10, DEINT → `acc`=5, then 0 (clamped); `Vint_z`=1 after the 2nd edge; drops after `ch_vr`=0.
- `ch_vm`=`ch_vr`=1 for one edge → `err`=1, `phase`=000; subsequent legal commands are ignored until `rst_s`; after reset, `err`=0.
- `rst_s` pulsed between clock edges mid-DEINT with `acc`=2000 → `vint`=0, `Vint_z`=0, `phase`=000 immediately.
